// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF / ON / BLINK / PWM.
// Channels are configured through a valid/ready write port.
module led_pattern_gen #(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 50000000,
    parameter int DUTY_W   = 8,
    parameter int RATE_W   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [DUTY_W-1:0]   cfg_duty,
    input  logic [RATE_W-1:0]   cfg_rate,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] led
);

    localparam int PS_W = $clog2(PRESCALE);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    logic                accept;
    logic                chan_ok;
    logic                tick;
    logic [PS_W-1:0]     ps_cnt;
    logic [DUTY_W-1:0]   pwm_cnt;
    logic [CHANNELS-1:0] led_nxt;

    assign accept  = cfg_valid & cfg_ready;
    assign chan_ok = {1'b0, cfg_chan} < 5'(CHANNELS);
    assign tick    = (ps_cnt == PS_W'(PRESCALE - 1));

    // Handshake: busy for one cycle after each accepted write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= ~accept;
            cfg_err   <= accept & ~chan_ok;
        end
    end

    // Prescaler producing the blink tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // Free-running PWM counter shared by all channels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        mode_t             mode_q;
        logic [DUTY_W-1:0] duty_q;
        logic [RATE_W-1:0] rate_q;
        logic [RATE_W-1:0] cnt_q;
        logic              phase_q;
        logic              hit;
        logic [RATE_W:0]   cnt_inc;
        logic [RATE_W:0]   rate_min;

        assign hit      = accept & chan_ok & (cfg_chan == 4'(g));
        assign cnt_inc  = {1'b0, cnt_q} + (RATE_W+1)'(1);
        assign rate_min = (rate_q == '0) ? (RATE_W+1)'(1)
                                         : {1'b0, rate_q};

        // Channel config and blink state; a write wins over a tick.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                mode_q  <= MODE_OFF;
                duty_q  <= '0;
                rate_q  <= '0;
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (hit) begin
                mode_q  <= mode_t'(cfg_mode);
                duty_q  <= cfg_duty;
                rate_q  <= cfg_rate;
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (mode_q != MODE_BLINK) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (tick) begin
                if (cnt_inc >= rate_min) begin
                    cnt_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    cnt_q   <= cnt_inc[RATE_W-1:0];
                end
            end
        end

        // Next LED level from the channel mode.
        always_comb begin
            led_nxt[g] = 1'b0;
            unique case (mode_q)
                MODE_OFF:   led_nxt[g] = 1'b0;
                MODE_ON:    led_nxt[g] = 1'b1;
                MODE_BLINK: led_nxt[g] = phase_q;
                MODE_PWM:   led_nxt[g] = (pwm_cnt < duty_q);
                default:    led_nxt[g] = 1'b0;
            endcase
        end
    end

    // Registered LED drive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen.
// Reference derives LED levels from elapsed edges since each write.
module tb_led_pattern_gen;

    localparam int P  = 4;
    localparam int CH = 4;

    logic       clock;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_chan;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_duty;
    logic [7:0] cfg_rate;
    logic       cfg_err;
    logic [3:0] led;

    led_pattern_gen #(
        .CHANNELS(CH),
        .PRESCALE(P),
        .DUTY_W(8),
        .RATE_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan),
        .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty),
        .cfg_rate(cfg_rate),
        .cfg_err(cfg_err),
        .led(led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk;
    int n_pass;
    int k;
    logic exp_ready;
    logic [3:0] last_exp;

    int m_mode [CH];
    int m_duty [CH];
    int m_rate [CH];
    int m_w    [CH];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (edge %0d)",
                      tag, obs, exp, k);
    endtask

    function automatic logic [3:0] exp_led(input int e);
        logic [3:0] v;
        int n;
        int r;
        v = '0;
        for (int i = 0; i < CH; i++) begin
            case (m_mode[i])
                1: v[i] = 1'b1;
                2: begin
                    n = e / P - (m_w[i] + 1) / P;
                    r = (m_rate[i] == 0) ? 1 : m_rate[i];
                    v[i] = ((n / r) % 2) == 1;
                end
                3: v[i] = (e % 256) < m_duty[i];
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            m_mode[i] = 0;
            m_duty[i] = 0;
            m_rate[i] = 0;
            m_w[i]    = 0;
        end
        k = 0;
        exp_ready = 1'b0;
    endtask

    task automatic step(input logic v, input logic [3:0] ch,
                        input logic [1:0] md, input logic [7:0] dt,
                        input logic [7:0] rt);
        logic acc;
        cfg_valid = v;
        cfg_chan  = ch;
        cfg_mode  = md;
        cfg_duty  = dt;
        cfg_rate  = rt;
        @(posedge clock);
        #1;
        acc = v && exp_ready;
        last_exp = exp_led(k);
        chk("led", led, last_exp);
        chk("ready", cfg_ready, !acc);
        chk("err", cfg_err, acc && (ch >= CH));
        if (acc && ch < CH) begin
            m_mode[ch] = md;
            m_duty[ch] = dt;
            m_rate[ch] = rt;
            m_w[ch]    = k;
        end
        exp_ready = !acc;
        k++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 2'd0, 8'd0, 8'd0);
    endtask

    task automatic rand_run(input int n, input int wprob);
        logic [7:0] dt;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: dt = 8'd0;
                1: dt = 8'd255;
                2: dt = 8'd64;
                default: dt = 8'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, wprob - 1) == 0,
                 4'($urandom_range(0, 5)),
                 2'($urandom_range(0, 3)),
                 dt,
                 8'($urandom_range(0, 4)));
        end
    endtask

    // Async reset between edges; a write pending during reset is dropped.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        cfg_valid = 1'b1;
        cfg_chan = 4'd0;
        cfg_mode = 2'd1;
        #1;
        chk("rst_led", led, 4'b0000);
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_hold_ready", cfg_ready, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        cfg_valid = 1'b0;
        model_clear();
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan = '0;
        cfg_mode = '0;
        cfg_duty = '0;
        cfg_rate = '0;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        chk("init_led", led, 4'b0000);
        chk("init_ready", cfg_ready, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        model_clear();

        idle(2);
        step(1'b1, 4'd0, 2'd1, 8'd0, 8'd0);
        step(1'b1, 4'd1, 2'd0, 8'd0, 8'd0);
        step(1'b1, 4'd1, 2'd0, 8'd0, 8'd0);
        step(1'b1, 4'd2, 2'd2, 8'd0, 8'd3);
        idle(1);
        step(1'b1, 4'd3, 2'd3, 8'd64, 8'd0);
        idle(1);
        step(1'b1, 4'd5, 2'd1, 8'd0, 8'd0);
        idle(600);
        step(1'b1, 4'd2, 2'd2, 8'd0, 8'd0);
        idle(1);
        step(1'b1, 4'd3, 2'd3, 8'd0, 8'd0);
        idle(300);
        step(1'b1, 4'd3, 2'd3, 8'd255, 8'd0);
        idle(520);

        rand_run(1500, 3);
        rand_run(1500, 40);

        step(1'b1, 4'd2, 2'd2, 8'd0, 8'd0);
        for (int j = 0; j < 12 && !last_exp[2]; j++) idle(1);
        chk("pre_rst_led2", led[2], 1'b1);
        do_reset();

        idle(3);
        rand_run(800, 4);
        do_reset();
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of independent LED outputs (1..16).
REQ-002 The block SHALL have parameter PRESCALE, default 50000000, clock cycles per blink tick (>=2).
REQ-003 The block SHALL have parameter DUTY_W, default 8, PWM duty/counter width.
REQ-004 The block SHALL have parameter RATE_W, default 8, blink half-period width in ticks.
REQ-005 The block SHALL have port clock, input, 1, sole clock; all logic on rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 The block SHALL have port cfg_valid, input, 1, configuration write request.
REQ-008 The block SHALL have port cfg_ready, output, 1, block can accept a write.
REQ-009 The block SHALL have port cfg_chan, input, 4, target channel index.
REQ-010 The block SHALL have port cfg_mode, input, 2, mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-011 The block SHALL have port cfg_duty, input, DUTY_W, PWM duty for mode 3.
REQ-012 The block SHALL have port cfg_rate, input, RATE_W, blink half-period in ticks for mode 2.
REQ-013 The block SHALL have port cfg_err, output, 1, one-cycle pulse on rejected write.
REQ-014 The block SHALL have port led, output, CHANNELS, registered LED drive, bit i = channel i.

Function
REQ-015 The block SHALL hold per-channel registers mode, duty, rate, blink count, and blink phase.
REQ-016 The block SHALL drive cfg_ready high in every cycle except the cycle immediately after an accepted write.
REQ-017 The block SHALL accept a write on a rising edge where cfg_valid and cfg_ready are both high.
REQ-018 On an accepted write with cfg_chan < CHANNELS, the block SHALL load mode, duty, and rate into that channel and clear its blink count and phase.
REQ-019 On an accepted write with cfg_chan >= CHANNELS, the block SHALL change no state and SHALL pulse cfg_err high for exactly the next cycle.
REQ-020 Prescaler: the block SHALL count 0..PRESCALE-1, wrap to 0, and assert a one-cycle tick when the count equals PRESCALE-1.
REQ-021 PWM counter: the block SHALL use a DUTY_W-bit counter that increments every cycle and wraps from 2^DUTY_W-1 to 0; it is shared by all channels.
REQ-022 BLINK: on each tick the block SHALL increment the channel blink count; when count+1 >= max(rate,1), it SHALL toggle the phase and clear the count.
REQ-023 A write landing in a tick cycle SHALL take priority over the tick for that channel; the other channels SHALL still count.
REQ-024 The next value of led[i] SHALL be 0 for OFF, 1 for ON, phase for BLINK, and (pwm_cnt < duty) for PWM.
REQ-025 Consequences of REQ-024: duty 0 SHALL give a constant 0; duty 2^DUTY_W-1 SHALL give a high level for 2^DUTY_W-1 of every 2^DUTY_W cycles.
REQ-026 led SHALL update one cycle after the state that determines it, and a write SHALL become visible on led no later than 2 cycles after acceptance.
REQ-027 Blink count and phase SHALL keep running only in BLINK mode and SHALL be held at 0 in other modes.

Reset
REQ-028 While reset is high, the block SHALL immediately and asynchronously force led=0, cfg_ready=0, cfg_err=0, and all counters, modes, duties, rates, and phases to 0.
REQ-029 After reset deasserts, the block SHALL raise cfg_ready on the first rising edge, and all channels SHALL start in OFF.
REQ-030 Reset asserted during a write or mid-blink SHALL discard the write and all state, with no partial update retained.

Verification (PRESCALE=4, CHANNELS=4, DUTY_W=8, RATE_W=8)
REQ-031 Reset pulse -> led=0000, cfg_ready=0 during reset, cfg_ready=1 one edge after release.
REQ-032 Write chan0 ON, then chan1 OFF -> led[0]=1 within 2 cycles; cfg_ready low for the one cycle after each accept.
REQ-033 Write chan2 BLINK rate=3 -> led[2] toggles every 12 cycles (50% duty, period 24); with rate=0 it toggles every 4 cycles.
REQ-034 Write chan3 PWM duty=64 -> led[3] high for exactly 64 of each 256 cycles; duty=0 gives constant 0.
REQ-035 Write with cfg_chan=5 -> cfg_err high for exactly 1 cycle, led unchanged; a write landing in a tick cycle -> blink restarts from phase 0.
REQ-036 Assert reset mid-blink with led[2]=1 -> led drops to 0 asynchronously, before the next clock edge.
